// File: rtl/simp_pipe_builtin_n.sv
// Two-stage unsigned vector adder: a carry-save array of 3:2 compressors reduces
// INPUT_VEC_LEN operands to a registered sum/carry pair, then a built-in '+' resolves it.
module simp_pipe_builtin_n #(
  parameter int INPUT_VEC_LEN = 8,
  parameter int WIDTH         = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [INPUT_VEC_LEN-1:0][WIDTH-1:0]   in,
  output logic [WIDTH-1:0]                      s
);

  logic [WIDTH-1:0] red_sum;
  logic [WIDTH-1:0] red_carry;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;

  generate
    if (INPUT_VEC_LEN == 1) begin : g_single
      assign red_sum   = in[0];
      assign red_carry = '0;
    end else begin : g_csa
      // Node i holds the partial (sum, carry) after folding operands 0..i+1.
      logic [WIDTH-1:0] ps [INPUT_VEC_LEN-1];
      logic [WIDTH-1:0] pc [INPUT_VEC_LEN-1];

      assign ps[0] = in[0];
      assign pc[0] = in[1];

      for (genvar i = 0; i < INPUT_VEC_LEN - 2; i++) begin : g_fa
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        assign a = ps[i];
        assign b = pc[i];
        assign c = in[i+2];
        assign ps[i+1] = a ^ b ^ c;
        // Carry moves up one weight; the top carry-out falls off (mod 2^WIDTH).
        assign pc[i+1] = ((a & b) | (a & c) | (b & c)) << 1;
      end

      assign red_sum   = ps[INPUT_VEC_LEN-2];
      assign red_carry = pc[INPUT_VEC_LEN-2];
    end
  endgenerate

  assign s_d = sum_q + carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      s_q     <= '0;
    end else begin
      sum_q   <= red_sum;
      carry_q <= red_carry;
      s_q     <= s_d;
    end
  end

  assign s = s_q;

endmodule

// File: tb/tb_simp_pipe_builtin_n.sv
// Directed and random checks of simp_pipe_builtin_n across several sizes sharing one
// operand stream; a behavioural sum model with a two-edge delay supplies expectations.
module tb_simp_pipe_builtin_n;

  localparam int NDUT = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] op    [8];
  logic [15:0] s_all [NDUT];
  logic [15:0] st1   [NDUT];
  logic [15:0] exp_s [NDUT];
  int          checks;
  int          errors;

  function automatic int nn_of(int g);
    case (g % 4)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  function automatic int ww_of(int g);
    return (g < 4) ? 8 : 16;
  endfunction

  generate
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int NN = nn_of(g);
      localparam int WW = ww_of(g);
      logic [NN-1:0][WW-1:0] vin;
      logic [WW-1:0]         sout;

      always_comb begin
        vin = '0;
        for (int j = 0; j < NN; j++) vin[j] = op[j][WW-1:0];
      end

      simp_pipe_builtin_n #(.INPUT_VEC_LEN(NN), .WIDTH(WW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (vin),
        .s     (sout)
      );

      assign s_all[g] = 16'(sout);
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] ref_sum(int n, int w);
    logic [31:0] acc;
    logic [31:0] m;
    acc = 32'd0;
    for (int j = 0; j < n; j++) acc = acc + 32'(op[j]);
    m = (32'd1 << w) - 32'd1;
    return acc[15:0] & m[15:0];
  endfunction

  // Model advances at the rising edge; inputs only change on the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int g = 0; g < NDUT; g++) begin
      exp_s[g] = rst_n ? st1[g] : 16'd0;
      st1[g]   = rst_n ? ref_sum(nn_of(g), ww_of(g)) : 16'd0;
    end
    @(negedge clk);
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(string tag);
    for (int g = 0; g < NDUT; g++)
      check($sformatf("%s_n%0d_w%0d", tag, nn_of(g), ww_of(g)), s_all[g], exp_s[g]);
  endtask

  task automatic rand_ops();
    for (int j = 0; j < 8; j++) op[j] = 16'($urandom());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      st1[g]   = 16'd0;
      exp_s[g] = 16'd0;
    end
    rand_ops();
    @(negedge clk);

    // Held reset: outputs stay zero whatever the operands do.
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      tick();
      for (int g = 0; g < NDUT; g++) check($sformatf("reset_hold_g%0d", g), s_all[g], 16'd0);
    end

    // Basic vector 1..8, released together with reset.
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) op[j] = 16'(j + 1);
    tick();
    check("basic_lat1_main", s_all[7], 16'd0);
    rand_ops();
    tick();
    check("basic_n8_w16", s_all[7], 16'd36);
    check("basic_n1_w16", s_all[4], 16'd1);
    check("basic_n2_w16", s_all[5], 16'd3);
    check("basic_n3_w8",  s_all[2], 16'd6);
    check_all("basic_model");

    // Overflow: every operand all-ones.
    for (int j = 0; j < 8; j++) op[j] = 16'hFFFF;
    tick();
    check_all("ovf_lat1_model");
    rand_ops();
    tick();
    check("ovf_n8_w16", s_all[7], 16'hFFF8);
    check("ovf_n8_w8",  s_all[3], 16'h00F8);
    check("ovf_n3_w16", s_all[6], 16'hFFFD);
    check("ovf_n2_w8",  s_all[1], 16'h00FE);
    check("ovf_n1_w8",  s_all[0], 16'h00FF);
    check_all("ovf_model");

    // Back-to-back random stream, every size at once.
    for (int k = 0; k < 50; k++) begin
      rand_ops();
      tick();
      check_all("stream");
    end

    // Mid-stream reset: in-flight sums must never surface.
    for (int j = 0; j < 8; j++) op[j] = 16'h0101 * 16'(j + 1);
    tick();
    for (int j = 0; j < 8; j++) op[j] = 16'h0011;
    tick();
    check_all("pre_reset");
    rst_n = 1'b0;
    tick();
    check("midrst_edge_main", s_all[7], 16'd0);
    check_all("midrst_edge");
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) op[j] = 16'(10 * (j + 1));
    tick();
    check("midrst_post1_main", s_all[7], 16'd0);
    check_all("midrst_post1");
    rand_ops();
    tick();
    check("midrst_post2_main", s_all[7], 16'd360);
    check_all("midrst_post2");

    // A short random tail after recovery.
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      tick();
      check_all("tail");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simp_pipe_builtin_n.md
SIMP_PIPE_BUILTIN_N -- requirements
Module: simp_pipe_builtin_N

Interface
REQ-001 Parameter INPUT_VEC_LEN, default 8: number of operands summed per cycle; legal range 1 or greater.
REQ-002 Parameter WIDTH, default 16: bit width of each operand and of the result.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in, input, packed [INPUT_VEC_LEN-1:0][WIDTH-1:0]: operand vector; element j is operand j, unsigned.
REQ-006 Port s, output, WIDTH bits: registered sum of one earlier operand vector.
REQ-007 The block SHALL have no other ports: no valid, ready or enable signals.

Function
REQ-008 The block SHALL compute s = (in[0] + in[1] + ... + in[INPUT_VEC_LEN-1]) mod 2^WIDTH.
- All operands and the result are unsigned.
- Overflow beyond WIDTH bits SHALL be discarded silently.
REQ-009 Stage 1 SHALL reduce the INPUT_VEC_LEN operands to two WIDTH-bit vectors (sum, carry) with a carry-save tree of 3:2 compressors.
- Tree: full-adder cells built from XOR/AND/OR equations.
- Carry vector: shifted left 1 bit, MSB carry-out dropped.
- Both vectors SHALL be captured in pipeline registers.
REQ-010 Stage 2 SHALL add the registered sum and carry vectors with the built-in '+' operator, truncate to WIDTH bits and register the result into s.
REQ-011 Latency SHALL be exactly 2 rising edges.
- An in value sampled at edge k SHALL appear on s immediately after edge k+1.
- Per-edge behaviour: stage 1 captures in at edge k; stage 2 updates s at edge k+1.
REQ-012 Throughput SHALL be one operand vector per clock.
- The pipeline never stalls.
- Every edge accepts a new in, with no bubbles.
REQ-013 Degenerate sizes:
- INPUT_VEC_LEN=1: stage 1 SHALL pass in[0] as the sum vector and zero as the carry vector.
- INPUT_VEC_LEN=2: stage 1 SHALL register the two operands directly as the sum and carry vectors.
- Latency SHALL remain 2 in both cases.
REQ-014 The CSA tree SHALL be generated structurally from INPUT_VEC_LEN (generate loops); no per-size hand-coded trees.
REQ-015 s SHALL depend only on registered state and never combinationally on in.

Reset
REQ-016 When rst_n=0 at a rising edge, all stage-1 registers and s SHALL clear to 0 at that edge.
REQ-017 While rst_n is held low, s SHALL read 0 regardless of in.
REQ-018 After rst_n rises, the first vector sampled with rst_n=1 at edge k SHALL produce its sum on s after edge k+1.
REQ-019 Reset asserted mid-stream SHALL discard all in-flight sums.
- No pre-reset sum SHALL appear on s after the reset edge.
REQ-020 Reset SHALL have no asynchronous effect: a rst_n pulse between edges has no effect.

Verification
REQ-021 Reset check: hold rst_n=0 for 5 edges with in random -> s=0 throughout.
REQ-022 Basic check: N=8, W=16, in = {1,2,3,4,5,6,7,8} -> s=36 two edges later.
REQ-023 Overflow check: all operands 16'hFFFF, N=8 -> s = 16'hFFF8.
- Full sum 0x7FFF8, truncated to 16 bits.
REQ-024 Streaming check: 50 consecutive random vectors, one per edge.
- Each s SHALL equal the reference model's sum mod 2^16 of the vector from 2 edges earlier.
- Zero mismatches required.
REQ-025 Mid-stream reset check: drive nonzero vectors, assert rst_n=0 for 1 edge, then release.
- s=0 from the reset edge until the first post-reset vector's sum arrives.
REQ-026 Parameter sweep: INPUT_VEC_LEN in {1, 2, 3, 8} with WIDTH in {8, 16}.
- Random streaming SHALL match the reference model at latency 2 for every combination.
